// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants shared by the
// timing generator and the renderer, plus the axis-total helper.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CW       = 11;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (pixel or line) wrapping at TOTAL-1.
// wrap_in chains the terminal count so wrap_out of the v axis marks frame end.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          wrap_in,
    output logic [CW-1:0] count,
    output logic          wrap_out
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    assign wrap_out = wrap_in && (count == LAST);

    // Reset parks on the last position so the first advance lands on 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LAST;
        end else if (ce) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel clock-enable.
// hsync/vsync/de can be delayed PIPE_DLY pixels to match a pixel pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CW       = DEF_CW,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIPE_DLY = 0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_timing_gen: H_SYNC and V_SYNC must be non-zero");
    end
    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7 || CLK_DIV < 1) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..7, CLK_DIV >= 1");
    end

    logic [DW-1:0] div;
    logic          tick;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          h_wrap;
    logic          f_wrap;
    logic [CW-1:0] h_n;
    logic [CW-1:0] v_n;
    logic          act;
    logic          hs_on;
    logic          vs_on;

    logic [PIPE_DLY:0] hs_sr;
    logic [PIPE_DLY:0] vs_sr;
    logic [PIPE_DLY:0] de_sr;

    assign tick = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
        end
    end

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .CW    (CW)
    ) u_h (
        .clk      (clk),
        .reset    (reset),
        .ce       (tick),
        .wrap_in  (1'b1),
        .count    (h),
        .wrap_out (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .CW    (CW)
    ) u_v (
        .clk      (clk),
        .reset    (reset),
        .ce       (tick & h_wrap),
        .wrap_in  (h_wrap),
        .count    (v),
        .wrap_out (f_wrap)
    );

    // Decode the position the counters move to on this tick.
    always_comb begin
        h_n = h_wrap ? '0 : h + CW'(1);
        v_n = v;
        if (h_wrap) begin
            v_n = f_wrap ? '0 : v + CW'(1);
        end
        act   = (h_n < HA) && (v_n < VA);
        hs_on = (h_n >= HS0) && (h_n < HS1);
        vs_on = (v_n >= VS0) && (v_n < VS1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ce      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs_sr       <= {(PIPE_DLY + 1){~H_POL}};
            vs_sr       <= {(PIPE_DLY + 1){~V_POL}};
            de_sr       <= '0;
        end else begin
            pix_ce <= tick;
            if (tick) begin
                x           <= act ? h_n : '0;
                y           <= act ? v_n : '0;
                line_start  <= (h_n == '0);
                frame_start <= (h_n == '0) && (v_n == '0);
                hs_sr[0]    <= hs_on ? H_POL : ~H_POL;
                vs_sr[0]    <= vs_on ? V_POL : ~V_POL;
                de_sr[0]    <= act;
                for (int i = 1; i <= PIPE_DLY; i++) begin
                    hs_sr[i] <= hs_sr[i-1];
                    vs_sr[i] <= vs_sr[i-1];
                    de_sr[i] <= de_sr[i-1];
                end
            end
        end
    end

    assign hsync = hs_sr[PIPE_DLY];
    assign vsync = vs_sr[PIPE_DLY];
    assign de    = de_sr[PIPE_DLY];

endmodule
